altair_pic: RTL and testbench

//  Priority interrupt controller for the Altair i8080 system. It replaces the tied-off intr input.
//  It latches up to 8 peripheral requests, drives cpu intr, and supplies an RST n opcode on idata during INTA.
//  It tracks in-service levels until software issues EOI.

---
 rtl/altair_pic.sv | 97 +++++++++
 tb/tb_altair_pic.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/altair_pic.sv
// altair_pic: 8-level priority interrupt controller supplying RST n opcodes to an i8080 core
module altair_pic #(
    parameter logic [7:0] SPURIOUS_VEC = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] irq,
    input  logic       addr,
    input  logic [7:0] data_in,
    input  logic       rd,
    input  logic       we,
    output logic [7:0] data_out,
    input  logic       inte,
    input  logic       inta_n,
    output logic       intr,
    output logic [7:0] vec_out,
    output logic       vec_valid
);
    typedef enum logic {IDLE, ACK} state_t;
    state_t state, state_d;
    logic [7:0] irq_s1, irq_s2, irq_d, irr, imr, isr;
    logic [7:0] irq_rise, isr_pre, elig, ack_bit, isr_eoi;
    logic [2:0] ack_n;
    logic inta_q, inta_qq, inta_fall, inta_rise, take;
    logic eoi_wr, eoi_ns, eoi_sp;

    assign irq_rise  = irq_s2 & ~irq_d;
    assign inta_fall = inta_qq & ~inta_q;
    assign inta_rise = ~inta_qq & inta_q;
    assign take      = (state == IDLE) && inta_fall;
    // a level is blocked by any in-service level of equal or higher priority
    assign isr_pre   = isr | (isr << 1) | (isr << 2) | (isr << 3) | (isr << 4) | (isr << 5) | (isr << 6) | (isr << 7);
    assign elig      = irr & ~imr & ~isr_pre;
    assign ack_bit   = elig & (~elig + 8'd1);
    assign ack_n     = {|(ack_bit & 8'hF0), |(ack_bit & 8'hCC), |(ack_bit & 8'hAA)};
    assign eoi_wr    = we && addr;
    assign eoi_ns    = eoi_wr && data_in[7];
    assign eoi_sp    = eoi_wr && !data_in[7] && data_in[6];
    assign isr_eoi   = eoi_ns ? (isr & (isr - 8'd1)) : eoi_sp ? (isr & ~(8'd1 << data_in[2:0])) : isr;

    // synchronize request lines and the acknowledge strobe, keep previous samples for edge detect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_s1  <= '0;
            irq_s2  <= '0;
            irq_d   <= '0;
            inta_q  <= 1'b1;
            inta_qq <= 1'b1;
        end else begin
            irq_s1  <= irq;
            irq_s2  <= irq_s1;
            irq_d   <= irq_s2;
            inta_q  <= inta_n;
            inta_qq <= inta_q;
        end
    end

    // acknowledge state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    // enter ACK on the acknowledge fall, leave on its rise
    always_comb begin
        state_d = state;
        state_d = (state == IDLE) ? (inta_fall ? ACK : IDLE) : (inta_rise ? IDLE : ACK);
    end

    // request, mask and in-service registers; a new edge wins over the ack clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irr      <= '0;
            imr      <= 8'hFF;
            isr      <= '0;
            data_out <= '0;
        end else begin
            irr      <= (irr & ~(take ? ack_bit : 8'h00)) | irq_rise;
            isr      <= isr_eoi | (take ? ack_bit : 8'h00);
            imr      <= (we && !addr) ? data_in : imr;
            data_out <= rd ? (addr ? isr : irr) : data_out;
        end
    end

    // cpu-facing outputs; the vector is frozen for the whole acknowledge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            intr      <= 1'b0;
            vec_out   <= SPURIOUS_VEC;
            vec_valid <= 1'b0;
        end else begin
            intr      <= inte && (|elig) && (state == IDLE) && !take;
            vec_out   <= take ? ((|elig) ? (8'hC7 | {2'b00, ack_n, 3'b000}) : SPURIOUS_VEC) : vec_out;
            vec_valid <= (state_d == ACK);
        end
    end
endmodule

// File: tb/tb_altair_pic.sv
// tb_altair_pic: directed vector and sequence bench for the interrupt controller
module tb_altair_pic;
    logic       clk, reset, addr, rd, we, inte, inta_n;
    logic [7:0] irq, data_in;
    logic [7:0] data_out, vec_out;
    logic       intr, vec_valid;
    int checks, errors;

    typedef struct {
        logic [7:0] imr;
        logic [7:0] irq;
        logic       intr;
        logic [7:0] vec;
        logic [7:0] isr;
        logic [7:0] irr;
    } vec_t;
    vec_t tbl[8];

    altair_pic dut (
        .clk(clk), .reset(reset), .irq(irq), .addr(addr), .data_in(data_in),
        .rd(rd), .we(we), .data_out(data_out), .inte(inte), .inta_n(inta_n),
        .intr(intr), .vec_out(vec_out), .vec_valid(vec_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        addr = a; data_in = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rdreg(input logic a, output logic [7:0] d);
        addr = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        d = data_out;
    endtask

    task automatic pulse(input logic [7:0] p);
        irq = p;
        repeat (2) @(negedge clk);
        irq = 8'h00;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic ack(input string name, output logic [7:0] v);
        int n;
        n = 0;
        inta_n = 1'b0;
        while (!vec_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid"}, {7'd0, vec_valid}, 8'h01);
        v = vec_out;
        inta_n = 1'b1;
        repeat (3) @(negedge clk);
        chk({name, "_release"}, {7'd0, vec_valid}, 8'h00);
    endtask

    initial begin
        logic [7:0] v, r;
        int n;
        checks = 0; errors = 0;
        reset = 1'b0; irq = 8'h00; addr = 1'b0; data_in = 8'h00;
        rd = 1'b0; we = 1'b0; inte = 1'b1; inta_n = 1'b1;

        tbl[0] = '{8'h00, 8'h04, 1'b1, 8'hD7, 8'h04, 8'h00};
        tbl[1] = '{8'h00, 8'h22, 1'b1, 8'hCF, 8'h02, 8'h20};
        tbl[2] = '{8'h00, 8'h80, 1'b1, 8'hFF, 8'h80, 8'h00};
        tbl[3] = '{8'h01, 8'h01, 1'b0, 8'hFF, 8'h00, 8'h01};
        tbl[4] = '{8'hF0, 8'h30, 1'b0, 8'hFF, 8'h00, 8'h30};
        tbl[5] = '{8'h0F, 8'h18, 1'b1, 8'hE7, 8'h10, 8'h08};
        tbl[6] = '{8'h00, 8'h00, 1'b0, 8'hFF, 8'h00, 8'h00};
        tbl[7] = '{8'h00, 8'hFF, 1'b1, 8'hC7, 8'h01, 8'hFE};

        for (int i = 0; i < 6; i++) begin
            irq = (i % 2 == 0) ? 8'hFF : 8'h00;
            @(negedge clk);
        end
        chk("rst_intr", {7'd0, intr}, 8'h00);
        chk("rst_valid", {7'd0, vec_valid}, 8'h00);
        chk("rst_vec", vec_out, 8'hFF);
        chk("rst_dout", data_out, 8'h00);
        irq = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        pulse(8'h08);
        rdreg(1'b0, r);
        chk("rst_irr", r, 8'h08);
        rdreg(1'b1, r);
        chk("rst_isr", r, 8'h00);
        chk("rst_masked_intr", {7'd0, intr}, 8'h00);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            wr(1'b0, tbl[i].imr);
            pulse(tbl[i].irq);
            chk($sformatf("v%0d_intr", i), {7'd0, intr}, {7'd0, tbl[i].intr});
            ack($sformatf("v%0d_ack", i), v);
            chk($sformatf("v%0d_vec", i), v, tbl[i].vec);
            rdreg(1'b1, r);
            chk($sformatf("v%0d_isr", i), r, tbl[i].isr);
            rdreg(1'b0, r);
            chk($sformatf("v%0d_irr", i), r, tbl[i].irr);
        end

        do_reset();
        wr(1'b0, 8'h00);
        irq = 8'h04;
        for (n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (intr) break;
        end
        irq = 8'h00;
        chk("basic_latency", {7'd0, intr}, 8'h01);
        repeat (3) @(negedge clk);
        ack("basic_ack", v);
        chk("basic_vec", v, 8'hD7);
        rdreg(1'b1, r);
        chk("basic_isr", r, 8'h04);
        rdreg(1'b0, r);
        chk("basic_irr", r, 8'h00);
        chk("basic_intr_low", {7'd0, intr}, 8'h00);

        ack("spur_ack", v);
        chk("spur_vec", v, 8'hFF);
        rdreg(1'b1, r);
        chk("spur_isr", r, 8'h04);

        pulse(8'h22);
        chk("nest_intr", {7'd0, intr}, 8'h01);
        ack("nest_ack", v);
        chk("nest_vec", v, 8'hCF);
        rdreg(1'b1, r);
        chk("nest_isr", r, 8'h06);
        wr(1'b1, 8'h80);
        rdreg(1'b1, r);
        chk("nest_eoi1_isr", r, 8'h04);
        repeat (3) @(negedge clk);
        chk("nest_blocked", {7'd0, intr}, 8'h00);
        wr(1'b1, 8'h80);
        repeat (3) @(negedge clk);
        chk("nest_unblocked", {7'd0, intr}, 8'h01);
        ack("nest_ack5", v);
        chk("nest_vec5", v, 8'hEF);
        rdreg(1'b1, r);
        chk("nest_isr5", r, 8'h20);
        wr(1'b1, 8'h45);
        rdreg(1'b1, r);
        chk("spec_eoi_isr", r, 8'h00);

        pulse(8'h04);
        chk("race_intr", {7'd0, intr}, 8'h01);
        irq = 8'h04;
        @(negedge clk);
        ack("race_ack", v);
        irq = 8'h00;
        chk("race_vec", v, 8'hD7);
        rdreg(1'b0, r);
        chk("race_irr", r, 8'h04);
        rdreg(1'b1, r);
        chk("race_isr", r, 8'h04);
        repeat (2) @(negedge clk);
        chk("race_intr_held", {7'd0, intr}, 8'h00);
        wr(1'b1, 8'h42);
        repeat (2) @(negedge clk);
        chk("race_intr_again", {7'd0, intr}, 8'h01);
        ack("race_ack2", v);
        chk("race_vec2", v, 8'hD7);
        rdreg(1'b0, r);
        chk("race_irr2", r, 8'h00);
        wr(1'b1, 8'h80);

        pulse(8'h01);
        inta_n = 1'b0;
        n = 0;
        while (!vec_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("midack_valid", {7'd0, vec_valid}, 8'h01);
        reset = 1'b0;
        #1;
        chk("midack_rst_valid", {7'd0, vec_valid}, 8'h00);
        chk("midack_rst_intr", {7'd0, intr}, 8'h00);
        chk("midack_rst_vec", vec_out, 8'hFF);
        inta_n = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        rdreg(1'b1, r);
        chk("midack_isr", r, 8'h00);
        wr(1'b0, 8'h00);
        pulse(8'h01);
        chk("midack_intr_after", {7'd0, intr}, 8'h01);
        ack("midack_ack", v);
        chk("midack_vec_after", v, 8'hC7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
